irq_controller: RTL and testbench
=================================

# irq_controller

Memory-mapped GBA interrupt controller in the I/O register space, directly downstream of the timer block. Registers the 14 interrupt sources, including the four timer-overflow pulses. Holds IE, IF and IME, drives the CPU IRQ line, and implements the HALT/STOP low-power handshake through HALTCNT. Sits on the same `clk_mem` I/O bus as the timer registers.

## Interface
Parameters:
- `NSRC`, 14: number of interrupt sources (IE/IF bits 13:0; bits 15:14 are reserved).

Ports:
- `clk_mem` in 1: system/memory clock. One clock only.
- `rst` in 1: reset, asynchronous, active-high.
- `addr` in 24: byte address within I/O space. Decode uses `addr[11:0]`, word aligned.
- `data_in` in 32: write data.
- `data_out` out 32: read data, combinational from `addr`.
- `read` in 1: read strobe. Reads have no side effects.
- `write` in 1: 32-bit word write, sampled on the rising edge.
- `tm_ovf` in 4: timer 0..3 overflow, from the timer block.
- `irq_src` in 14: level/pulse sources. Bits 3..6 are ORed with `tm_ovf[0..3]`.
- `irq` out 1: registered CPU interrupt request.
- `cpu_halt` out 1: registered; high while the CPU must be stalled.

## Operation
- Source bit order: 0 VBLANK, 1 HBLANK, 2 VCOUNT, 3-6 TIMER0-3, 7 SERIAL, 8-11 DMA0-3, 12 KEYPAD, 13 GAMEPAK.
- Rising-edge detection per source:
  - `src = irq_src | {tm_ovf at 6:3}`.
  - `src_q <= src` on every edge.
  - `rise = src & ~src_q`.
- Register map (word address):
  - 0x200: `[15:0]` IE, `[31:16]` IF.
  - 0x208: bit0 IME; other bits read 0.
  - 0x300: `[7:0]` POSTFLG; `[15:8]` HALTCNT, write-only, reads 0.
  - Reserved bits and unmapped addresses read 0.
- IE write: `IE <= data_in[13:0]`.
- IF update, every edge: `IF <= (IF & ~clr) | rise`.
  - `clr = data_in[29:16]` when writing 0x200, else 0.
  - Write-1-to-clear.
  - Set wins over clear in the same cycle, so no event is lost.
- IME write: `IME <= data_in[0]`.
- POSTFLG write: `POSTFLG <= data_in[0]`.
- `irq <= IME & |(IE & IF)`, computed from the register values before the edge.
- Power FSM, states RUN, HALT, STOP:
  - RUN → HALT: write to 0x300 with `data_in[15]=0`, and `(IE&IF)==0`.
  - RUN → STOP: write to 0x300 with `data_in[15]=1`, and `(IE&IF)==0`.
  - If `(IE&IF)!=0` at the write edge, the FSM stays in RUN.
  - HALT → RUN: when `|(IE & IF)`. IME is ignored.
  - STOP → RUN: only when `|(IE & IF & mask)`, where mask = bits 7, 12, 13.
  - `cpu_halt = (state != RUN)`, driven from the state register.

## Timing
- Reset values:
  - IE, IF, IME, POSTFLG, `src_q`: 0.
  - state: RUN.
  - `irq`: 0. `cpu_halt`: 0.
- Reset takes effect immediately. A source that is high at reset release counts as a rising edge on the first edge.
- Source latency: source first sampled high at edge k → IF bit set after edge k → `irq` high after edge k+1 (if IE and IME are set).
- A source held high sets IF once. A clear while it stays high is not re-set until the source falls and rises again.
- Clearing the last pending IF bit, IE bit or IME at edge k → `irq` low after edge k+1.
- HALTCNT write at edge k → `cpu_halt` high after edge k.
- Wake condition first true at edge j → `cpu_halt` low after edge j+1.
- `data_out` is valid in the same cycle as `addr`. A write and a read in the same cycle return the old value.

## Structure
- Shared package `gba_io_pkg` contains:
  - address constants `IO_IE_IF` = 0x200, `IO_IME` = 0x208, `IO_HALTCNT` = 0x300, plus the existing timer addresses 0x100-0x10C;
  - IRQ bit indices and `STOP_WAKE_MASK`;
  - power-state enum `{RUN, HALT, STOP}`.
- One sub-module, `irq_edge_detect`: NSRC-wide register plus rising-edge logic, with `clk_mem`/`rst`.

## Test plan
- **Timer overflow:** IE=0x0008, IME=1; pulse `tm_ovf[0]` for one cycle → IF=0x0008 after edge k, `irq`=1 after edge k+1. Write 0x200 with `data_in=0x0008_0008` → IF=0, then `irq`=0 one edge later.
- **Simultaneous set and clear:** write IF-clear 0x0001 while VBLANK rises in the same cycle → IF bit0 remains 1.
- **IME gating:** IE=0x3FFF, IME=0, all sources pulsed → IF=0x3FFF, `irq`=0. Write IME=1 → `irq`=1 one cycle later.
- **HALT:** write 0x300 with `data_in=0x0000` and IE=0x0001 → `cpu_halt`=1. VBLANK edge → IF bit0 set; `cpu_halt`=0 one edge later, with `irq`=0 because IME=0.
- **STOP:** write 0x300 with `data_in=0x8000`, IE=0x1009 → timer0 and VBLANK edges leave `cpu_halt`=1. KEYPAD edge → `cpu_halt`=0.
- **Reset:** assert `rst` mid-HALT with IF=0x0040 → `cpu_halt`, `irq`, IF and IE all 0 immediately. Read 0x208 → 0x00000000.

Source files
------------

// File: rtl/gba_io_pkg.sv
// Shared definitions for the GBA I/O register block.
// Holds the I/O address map, the interrupt source bit indices, the set of
// sources that may wake the CPU from STOP, and the power-state encoding.
package gba_io_pkg;

    // I/O register word addresses (decoded from addr[11:0])
    localparam logic [11:0] IO_TM0 = 12'h100;
    localparam logic [11:0] IO_TM1 = 12'h104;
    localparam logic [11:0] IO_TM2 = 12'h108;
    localparam logic [11:0] IO_TM3 = 12'h10C;
    localparam logic [11:0] IO_IE_IF = 12'h200;
    localparam logic [11:0] IO_IME = 12'h208;
    localparam logic [11:0] IO_HALTCNT = 12'h300;

    // Interrupt source bit positions in IE/IF
    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_HBLANK = 1;
    localparam int IRQ_VCOUNT = 2;
    localparam int IRQ_TIMER0 = 3;
    localparam int IRQ_TIMER1 = 4;
    localparam int IRQ_TIMER2 = 5;
    localparam int IRQ_TIMER3 = 6;
    localparam int IRQ_SERIAL = 7;
    localparam int IRQ_DMA0 = 8;
    localparam int IRQ_DMA1 = 9;
    localparam int IRQ_DMA2 = 10;
    localparam int IRQ_DMA3 = 11;
    localparam int IRQ_KEYPAD = 12;
    localparam int IRQ_GAMEPAK = 13;

    // Only SERIAL, KEYPAD and GAMEPAK may leave STOP: everything else is
    // clocked by blocks that are frozen while stopped.
    localparam logic [13:0] STOP_WAKE_MASK = 14'h3080;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        HALT = 2'd1,
        STOP = 2'd2
    } power_state_t;

endpackage

// File: rtl/irq_edge_detect.sv
// Per-source rising-edge detector for the interrupt controller.
// Ports:
//   clk_mem - system clock
//   rst     - asynchronous active-high reset
//   src     - NSRC raw source levels
//   rise    - one-cycle high where src is high now and was low last edge
// src_q resets to 0, so a source already high at reset release is seen as
// a rising edge on the first clock.
module irq_edge_detect #(
    parameter int NSRC = 14
) (
    input  logic            clk_mem,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    output logic [NSRC-1:0] rise
);

    logic [NSRC-1:0] src_q;

    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) src_q <= '0;
        else     src_q <= src;
    end

    assign rise = src & ~src_q;

endmodule

// File: rtl/irq_controller.sv
// GBA interrupt controller: IE / IF / IME registers, CPU IRQ line and the
// HALT/STOP low-power handshake through HALTCNT.
// Ports:
//   clk_mem, rst      - clock, asynchronous active-high reset
//   addr, data_in     - I/O bus address (addr[11:0] decoded) and write data
//   data_out          - combinational read data for addr
//   read, write       - bus strobes; reads have no side effects
//   tm_ovf            - timer 0..3 overflow pulses, merged into IF bits 6:3
//   irq_src           - remaining interrupt sources
//   irq               - registered CPU interrupt request
//   cpu_halt          - high while the CPU is held in HALT or STOP
module irq_controller
    import gba_io_pkg::*;
#(
    parameter int NSRC = 14
) (
    input  logic            clk_mem,
    input  logic            rst,
    input  logic [23:0]     addr,
    input  logic [31:0]     data_in,
    output logic [31:0]     data_out,
    input  logic            read,
    input  logic            write,
    input  logic [3:0]      tm_ovf,
    input  logic [NSRC-1:0] irq_src,
    output logic            irq,
    output logic            cpu_halt
);

    logic [NSRC-1:0] src, rise, clr, pending;
    logic [NSRC-1:0] ie, iflag;
    logic            ime, postflg;
    logic            hit_ie_if, hit_ime, hit_haltcnt;
    power_state_t    state, next_state;

    // Bus signals this block never looks at
    logic unused;
    assign unused = &{1'b0, read, addr[23:12], addr[1:0], data_in[31:30], data_in[14]};

    assign hit_ie_if   = (addr[11:2] == IO_IE_IF[11:2]);
    assign hit_ime     = (addr[11:2] == IO_IME[11:2]);
    assign hit_haltcnt = (addr[11:2] == IO_HALTCNT[11:2]);

    always_comb begin
        src = irq_src;
        src[IRQ_TIMER0 +: 4] = irq_src[IRQ_TIMER0 +: 4] | tm_ovf;
    end

    irq_edge_detect #(.NSRC(NSRC)) u_edge (
        .clk_mem (clk_mem),
        .rst     (rst),
        .src     (src),
        .rise    (rise)
    );

    // Write-1-to-clear; OR-ing rise in after the clear lets a new event win
    assign clr     = (write && hit_ie_if) ? data_in[16 +: NSRC] : '0;
    assign pending = ie & iflag;

    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) begin
            ie      <= '0;
            iflag   <= '0;
            ime     <= 1'b0;
            postflg <= 1'b0;
            irq     <= 1'b0;
        end else begin
            iflag <= (iflag & ~clr) | rise;
            irq   <= ime & (|pending);
            if (write && hit_ie_if)   ie      <= data_in[NSRC-1:0];
            if (write && hit_ime)     ime     <= data_in[0];
            if (write && hit_haltcnt) postflg <= data_in[0];
        end
    end

    // Power FSM
    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                // A pending enabled interrupt refuses the sleep request
                if (write && hit_haltcnt && !(|pending))
                    next_state = data_in[15] ? STOP : HALT;
            end
            HALT: if (|pending) next_state = RUN;
            STOP: if (|(pending & NSRC'(STOP_WAKE_MASK))) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    assign cpu_halt = (state != RUN);

    // Read mux; reserved bits and unmapped addresses return 0
    always_comb begin
        data_out = '0;
        if (hit_ie_if) begin
            data_out[NSRC-1:0]       = ie;
            data_out[16 +: NSRC]     = iflag;
        end else if (hit_ime) begin
            data_out[0] = ime;
        end else if (hit_haltcnt) begin
            data_out[0] = postflg;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller.
module tb_irq_controller;

    logic        clk_mem = 1'b0;
    logic        rst;
    logic [23:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        read, write;
    logic [3:0]  tm_ovf;
    logic [13:0] irq_src;
    logic        irq, cpu_halt;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rdata;

    irq_controller #(.NSRC(14)) dut (
        .clk_mem  (clk_mem),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .read     (read),
        .write    (write),
        .tm_ovf   (tm_ovf),
        .irq_src  (irq_src),
        .irq      (irq),
        .cpu_halt (cpu_halt)
    );

    always #5 clk_mem = ~clk_mem;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_mem);
        #1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        addr = a; data_in = d; write = 1'b1;
        tick();
        write = 1'b0; data_in = '0;
    endtask

    task automatic rd(input logic [23:0] a, output logic [31:0] d);
        addr = a; read = 1'b1;
        #1;
        d = data_out;
        read = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = '0; data_in = '0; read = 1'b0; write = 1'b0;
        tm_ovf = '0; irq_src = '0;
        #12;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_halt", {31'd0, cpu_halt}, 32'd0);
        rd(24'h000200, rdata); chk("rst_ie_if", rdata, 32'h0);
        rd(24'h000208, rdata); chk("rst_ime", rdata, 32'h0);
        @(posedge clk_mem); #1;
        rst = 1'b0;

        // Timer overflow path
        wr(24'h000200, 32'h0000_0008);
        wr(24'h000208, 32'h1);
        rd(24'h000208, rdata); chk("ime_read", rdata, 32'h1);
        tm_ovf = 4'b0001;
        tick();
        tm_ovf = 4'b0000;
        rd(24'h000200, rdata); chk("tm0_if_set", rdata, 32'h0008_0008);
        chk("tm0_irq_lag", {31'd0, irq}, 32'd0);
        tick();
        chk("tm0_irq", {31'd0, irq}, 32'd1);
        wr(24'h000200, 32'h0008_0008);
        rd(24'h000200, rdata); chk("tm0_if_clr", rdata, 32'h0000_0008);
        chk("tm0_irq_hold", {31'd0, irq}, 32'd1);
        tick();
        chk("tm0_irq_drop", {31'd0, irq}, 32'd0);
        rd(24'h000204, rdata); chk("unmapped", rdata, 32'h0);

        // Set beats clear in the same cycle; held source does not re-set
        irq_src = 14'h0001;
        wr(24'h000200, 32'h0001_0008);
        rd(24'h000200, rdata); chk("set_wins", rdata, 32'h0001_0008);
        wr(24'h000200, 32'h0001_0008);
        tick();
        rd(24'h000200, rdata); chk("held_no_reset", rdata, 32'h0000_0008);
        chk("held_irq", {31'd0, irq}, 32'd0);
        irq_src = 14'h0000;

        // IME gating
        wr(24'h000208, 32'h0);
        wr(24'h000200, 32'h0000_3FFF);
        irq_src = 14'h3FFF;
        tick();
        irq_src = 14'h0000;
        rd(24'h000200, rdata); chk("all_if", rdata, 32'h3FFF_3FFF);
        tick();
        chk("ime_gate", {31'd0, irq}, 32'd0);
        wr(24'h000208, 32'h1);
        chk("ime_lag", {31'd0, irq}, 32'd0);
        tick();
        chk("ime_irq", {31'd0, irq}, 32'd1);
        wr(24'h000200, 32'h3FFF_0000);
        wr(24'h000208, 32'h0);
        tick();
        chk("all_clr_irq", {31'd0, irq}, 32'd0);

        // HALT
        wr(24'h000200, 32'h0000_0001);
        wr(24'h000300, 32'h0000_0000);
        chk("halt_enter", {31'd0, cpu_halt}, 32'd1);
        tick();
        chk("halt_stay", {31'd0, cpu_halt}, 32'd1);
        irq_src = 14'h0001;
        tick();
        irq_src = 14'h0000;
        chk("halt_wake_lag", {31'd0, cpu_halt}, 32'd1);
        tick();
        chk("halt_wake", {31'd0, cpu_halt}, 32'd0);
        chk("halt_irq_off", {31'd0, irq}, 32'd0);
        rd(24'h000300, rdata); chk("postflg0", rdata, 32'h0);
        // Sleep refused while an enabled interrupt is pending
        wr(24'h000300, 32'h0000_0000);
        chk("halt_blocked", {31'd0, cpu_halt}, 32'd0);

        // STOP
        wr(24'h000200, 32'h0001_1009);
        wr(24'h000300, 32'h0000_8001);
        chk("stop_enter", {31'd0, cpu_halt}, 32'd1);
        rd(24'h000300, rdata); chk("postflg1", rdata, 32'h1);
        tm_ovf = 4'b0001;
        tick();
        tm_ovf = 4'b0000;
        irq_src = 14'h0001;
        tick();
        irq_src = 14'h0000;
        tick();
        chk("stop_hold", {31'd0, cpu_halt}, 32'd1);
        rd(24'h000200, rdata); chk("stop_if", rdata, 32'h0009_1009);
        irq_src = 14'h1000;
        tick();
        irq_src = 14'h0000;
        chk("stop_wake_lag", {31'd0, cpu_halt}, 32'd1);
        tick();
        chk("stop_wake", {31'd0, cpu_halt}, 32'd0);

        // Reset mid-HALT with IF=0x0040
        wr(24'h000200, 32'h3FFF_0001);
        wr(24'h000208, 32'h1);
        wr(24'h000300, 32'h0000_0000);
        tm_ovf = 4'b1000;
        tick();
        tm_ovf = 4'b0000;
        rd(24'h000200, rdata); chk("pre_rst_if", rdata, 32'h0040_0001);
        chk("pre_rst_halt", {31'd0, cpu_halt}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_halt", {31'd0, cpu_halt}, 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        rd(24'h000200, rdata); chk("mid_rst_ie_if", rdata, 32'h0);
        rd(24'h000208, rdata); chk("mid_rst_ime", rdata, 32'h0);

        // Source high at reset release counts as an edge
        irq_src = 14'h0002;
        @(posedge clk_mem); #1;
        rst = 1'b0;
        tick();
        rd(24'h000200, rdata); chk("rel_edge", rdata, 32'h0002_0000);
        irq_src = 14'h0000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
